// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler: six 4-bit requesters share one registered output word.
// Zero-valued words are acknowledged and counted as drops instead of being forwarded.
module mux_rr_scheduler #(
    parameter int DW    = 4,
    parameter int NREQ  = 6,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [2:0]         out_src,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [2:0]         ptr
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic [2:0]       out_src_q, out_src_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             window_open;
    logic             found;
    logic [2:0]       win;
    logic [DW-1:0]    win_data;

    function automatic logic [2:0] rr_index(input logic [2:0] base, input int unsigned off);
        int unsigned s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[2:0];
    endfunction

    assign window_open = rst_n && ((state_q == EMPTY) || out_ready);

    // Scan from the pointer; the first valid index wins.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        found    = 1'b0;
        win      = '0;
        win_data = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req_valid[rr_index(ptr_q, k)]) begin
                found = 1'b1;
                win   = rr_index(ptr_q, k);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win == 3'(i)) win_data = req_data[i*DW +: DW];
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (window_open && found && (win == 3'(i))) req_ready[i] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        ptr_d      = ptr_q;
        drop_cnt_d = drop_cnt_q;
        if (window_open) begin
            if (found) begin
                ptr_d = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
                if (win_data != '0) begin
                    state_d    = FULL;
                    out_data_d = win_data;
                    out_src_d  = win;
                end else begin
                    // A drop still completes any pending output handshake.
                    state_d = EMPTY;
                    if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_src_q  <= '0;
            ptr_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            ptr_q      <= ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign ptr       = ptr_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench for mux_rr_scheduler: directed vectors push expected words,
// a negedge monitor pops them on every output handshake.
module tb_mux_rr_scheduler;

    logic        clk;
    logic        rst_n;
    logic [5:0]  req_valid;
    logic [23:0] req_data;
    logic [5:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [2:0]  out_src;
    logic [7:0]  drop_cnt;
    logic [2:0]  ptr;

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] src;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mux_rr_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_src  (out_src),
        .drop_cnt (drop_cnt),
        .ptr      (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [3:0] val);
        req_data[idx*4 +: 4] = val;
    endtask

    task automatic expect_word(input logic [3:0] d, input logic [2:0] s);
        exp_t e;
        e.data = d;
        e.src  = s;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted output word must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data=0x%0h src=%0d, expected no word", out_data, out_src);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_src", 32'(out_src), 32'(e.src));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int bad_valid;
        int bad_ready;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state and combinational ready suppression during reset.
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_src", 32'(out_src), 0);
        check("rst_ptr", 32'(ptr), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        req_valid = 6'b111111;
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        req_valid = '0;

        // Single requester 2.
        rst_n     = 1'b1;
        out_ready = 1'b1;
        set_data(2, 4'h9);
        req_valid = 6'b000100;
        #1;
        check("t1_req_ready", 32'(req_ready), 32'h04);
        expect_word(4'h9, 3'd2);
        tick();
        check("t1_out_valid", 32'(out_valid), 1);
        check("t1_out_data", 32'(out_data), 9);
        check("t1_out_src", 32'(out_src), 2);
        check("t1_ptr", 32'(ptr), 3);
        req_valid = '0;
        tick();
        check("t1_drain", 32'(out_valid), 0);

        // All six valid from reset: grants 0..5,0 back to back.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) set_data(i, 4'(i + 1));
        req_valid = 6'b111111;
        for (int k = 0; k < 7; k++) begin
            #1;
            check("t2_req_ready", 32'(req_ready), 32'(1 << (k % 6)));
            expect_word(4'((k % 6) + 1), 3'(k % 6));
            tick();
            check("t2_out_valid", 32'(out_valid), 1);
            check("t2_ptr", 32'(ptr), 32'(((k % 6) + 1) % 6));
        end
        req_valid = '0;
        tick();
        check("t2_drain", 32'(out_valid), 0);

        // Backpressure with requesters 1 and 4 valid; ptr is 1 here.
        req_valid = 6'b010010;
        #1;
        check("t3_req_ready_first", 32'(req_ready), 32'h02);
        expect_word(4'h2, 3'd1);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_hold_ready", 32'(req_ready), 0);
            check("t3_hold_data", 32'(out_data), 2);
            check("t3_hold_src", 32'(out_src), 1);
            check("t3_hold_ptr", 32'(ptr), 2);
            check("t3_hold_valid", 32'(out_valid), 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("t3_req_ready_next", 32'(req_ready), 32'h10);
        expect_word(4'h5, 3'd4);
        tick();
        out_ready = 1'b0;
        req_valid = '0;
        #1;
        check("t3_next_valid", 32'(out_valid), 1);
        check("t3_next_data", 32'(out_data), 5);
        check("t3_next_src", 32'(out_src), 4);
        check("t3_next_ptr", 32'(ptr), 5);
        out_ready = 1'b1;
        tick();
        check("t3_drain", 32'(out_valid), 0);

        // Zero drop from requester 0, then requester 3 with 4'h7.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_data(0, 4'h0);
        set_data(3, 4'h7);
        req_valid = 6'b001001;
        #1;
        check("t4_req_ready_drop", 32'(req_ready), 32'h01);
        tick();
        check("t4_drop_cnt", 32'(drop_cnt), 1);
        check("t4_no_valid", 32'(out_valid), 0);
        check("t4_ptr", 32'(ptr), 1);
        req_valid = 6'b001000;
        #1;
        check("t4_req_ready_3", 32'(req_ready), 32'h08);
        expect_word(4'h7, 3'd3);
        tick();
        check("t4_out_data", 32'(out_data), 7);
        check("t4_out_src", 32'(out_src), 3);
        req_valid = '0;
        tick();

        // Saturation: 300 zero-data words from requester 5.
        set_data(5, 4'h0);
        req_valid = 6'b100000;
        bad_valid = 0;
        bad_ready = 0;
        for (int k = 0; k < 300; k++) begin
            #1;
            if (req_ready !== 6'b100000) bad_ready++;
            tick();
            if (out_valid !== 1'b0) bad_valid++;
        end
        check("t5_ready_each_cycle", 32'(bad_ready), 0);
        check("t5_valid_stays_low", 32'(bad_valid), 0);
        check("t5_drop_cnt_sat", 32'(drop_cnt), 255);
        check("t5_ptr", 32'(ptr), 0);
        #1;
        check("t5_ack_at_sat", 32'(req_ready), 32'h20);
        tick();
        check("t5_drop_cnt_hold", 32'(drop_cnt), 255);
        req_valid = '0;
        tick();

        // Reset while FULL with 4'hA held and out_ready low.
        out_ready = 1'b0;
        set_data(3, 4'hA);
        req_valid = 6'b001000;
        tick();
        req_valid = '0;
        #1;
        check("t6_held_data", 32'(out_data), 32'hA);
        check("t6_held_ptr", 32'(ptr), 4);
        rst_n     = 1'b0;
        req_valid = 6'b000110;
        #1;
        check("t6_rst_req_ready", 32'(req_ready), 0);
        tick();
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_ptr", 32'(ptr), 0);
        check("t6_rst_drop_cnt", 32'(drop_cnt), 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        set_data(2, 4'h9);
        req_valid = 6'b101100;
        #1;
        check("t6_first_grant", 32'(req_ready), 32'h04);
        expect_word(4'h9, 3'd2);
        tick();
        check("t6_out_src", 32'(out_src), 2);
        req_valid = '0;
        tick();
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
